seq_shift_add_multiplier: RTL and testbench

SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

---
 rtl/seq_shift_add_multiplier_pkg.sv | 14 +
 rtl/seq_shift_add_multiplier.sv | 126 ++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared defaults and FSM state type for the sequential shift-add multiplier.
package seq_shift_add_multiplier_pkg;

   localparam int unsigned QW_DEF = 16;
   localparam int unsigned YW_DEF = 32;
   localparam int unsigned PW_DEF = QW_DEF + YW_DEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 sequential shift-add multiplier, fixed QW-cycle latency, valid/ready on both sides.
// Define MUL_REM_ADD_EN to preload r_in so p_out = q_in*y_in + r_in (divider result check).
module seq_shift_add_multiplier
   import seq_shift_add_multiplier_pkg::*;
#(
   parameter int unsigned QW = QW_DEF,
   parameter int unsigned YW = YW_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [QW-1:0]      q_in,
   input  logic [YW-1:0]      y_in,
   input  logic [YW-1:0]      r_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [QW+YW-1:0]   p_out
);

   localparam int unsigned PW = QW + YW;
   localparam int unsigned CW = $clog2(QW + 1);

   mul_state_e      state_q, state_d;
   logic [PW-1:0]   p_q, p_d;
   logic [YW-1:0]   y_q, y_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;

   logic [YW-1:0]   preload;
   logic [YW:0]     hi_sum;
   logic            accept;
   logic            last_step;

`ifdef MUL_REM_ADD_EN
   assign preload = r_in;
`else
   logic unused_r_in;
   assign unused_r_in = ^r_in;
   assign preload     = '0;
`endif

   assign accept    = in_valid && (state_q == ST_IDLE);
   assign last_step = (cnt_q == CW'(1));

   // Conditional add of the multiplicand into the upper half, carry kept for the shift
   assign hi_sum = {1'b0, p_q[PW-1:QW]} + (p_q[0] ? {1'b0, y_q} : (YW+1)'(0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept)    state_d = ST_BUSY;
         ST_BUSY: if (last_step) state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Handshake flags are registered copies of the next-state decode
   always_comb begin
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      p_d   = p_q;
      y_d   = y_q;
      cnt_d = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               y_d   = y_in;
               p_d   = {preload, q_in};
               cnt_d = CW'(QW);
            end
         end
         ST_BUSY: begin
            p_d   = {hi_sum, p_q[QW-1:1]};
            cnt_d = cnt_q - CW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q   <= '0;
         y_q   <= '0;
         cnt_q <= '0;
      end else begin
         p_q   <= p_d;
         y_q   <= y_d;
         cnt_q <= cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign p_out     = p_q;

   a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(in_ready_q && out_valid_q));

   a_result_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid_q && !out_ready) |=> (out_valid_q && $stable(p_q)));

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Randomized self-checking bench for seq_shift_add_multiplier against an arithmetic model.
module tb_seq_shift_add_multiplier;

   localparam int unsigned QW = 16;
   localparam int unsigned YW = 32;
   localparam int unsigned PW = QW + YW;
`ifdef MUL_REM_ADD_EN
   localparam bit REM_EN = 1'b1;
`else
   localparam bit REM_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [QW-1:0] q_in;
   logic [YW-1:0] y_in;
   logic [YW-1:0] r_in;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] p_out;

   int checks = 0;
   int errors = 0;

   seq_shift_add_multiplier #(.QW(QW), .YW(YW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q_in      (q_in),
      .y_in      (y_in),
      .r_in      (r_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p_out     (p_out)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] model(input logic [QW-1:0] q, input logic [YW-1:0] y,
                                           input logic [YW-1:0] r);
      logic [63:0] m;
      m = 64'(q) * 64'(y);
      if (REM_EN) m = m + 64'(r);
      return m[PW-1:0];
   endfunction

   function automatic logic [QW-1:0] rand_q();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         default: return QW'($urandom);
      endcase
   endfunction

   function automatic logic [YW-1:0] rand_y();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         default: return YW'($urandom);
      endcase
   endfunction

   // Present operands until accepted, then scramble them to prove they are latched
   task automatic issue(input logic [QW-1:0] q, input logic [YW-1:0] y, input logic [YW-1:0] r);
      int n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready: in_ready=%b expected 1", in_ready);
      end
      in_valid = 1'b1;
      q_in = q;
      y_in = y;
      r_in = r;
      @(posedge clk); #1;
      in_valid = 1'b0;
      q_in = QW'($urandom);
      y_in = YW'($urandom);
      r_in = YW'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (out_valid !== 1'b1 && lat < 4 * QW);
      checks++;
      if (out_valid !== 1'b1 || lat != QW) begin
         errors++;
         $display("FAIL latency: out_valid=%b after %0d edges, expected 1 after %0d", out_valid, lat, QW);
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL handshake: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      q_in = '0;
      y_in = '0;
      r_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (p_out !== '0) begin
         errors++;
         $display("FAIL reset_p_out: got %h expected 0", p_out);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_zero_operand();
      int lat;
      logic [YW-1:0] r;
      r = YW'($urandom);
      issue('0, 32'h1234_5678, r);
      wait_done(lat);
      checks++;
      if (p_out !== model('0, 32'h1234_5678, r)) begin
         errors++;
         $display("FAIL zero_q: p_out=%h expected %h", p_out, model('0, 32'h1234_5678, r));
      end
      handshake();
   endtask

   task automatic test_max_operands();
      int lat;
      logic [PW-1:0] exp;
      exp = model('1, '1, 32'hFFFF_FFFE);
      out_ready = 1'b1;
      issue('1, '1, 32'hFFFF_FFFE);
      wait_done(lat);
      checks++;
      if (p_out !== exp) begin
         errors++;
         $display("FAIL max_operands: p_out=%h expected %h", p_out, exp);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL max_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_stall();
      int lat;
      logic [YW-1:0] r;
      logic [PW-1:0] exp;
      r = YW'($urandom);
      exp = model(16'h8000, 32'h0001_0000, r);
      issue(16'h8000, 32'h0001_0000, r);
      wait_done(lat);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || p_out !== exp) begin
            errors++;
            $display("FAIL stall_hold[%0d]: out_valid=%b p_out=%h expected 1/%h", i, out_valid, p_out, exp);
         end
         in_valid = 1'($urandom_range(0, 1));
         q_in = QW'($urandom);
         y_in = YW'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (p_out !== exp) begin
         errors++;
         $display("FAIL stall_final: p_out=%h expected %h", p_out, exp);
      end
      handshake();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_no_reaccept: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      bit seen = 1'b0;
      issue(QW'($urandom), YW'($urandom), YW'($urandom));
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || p_out !== '0) begin
         errors++;
         $display("FAIL abort_async: in_ready=%b out_valid=%b p_out=%h expected 1/0/0",
                  in_ready, out_valid, p_out);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3 * QW; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abort_no_valid: out_valid seen=1 expected 0");
      end
      issue(16'd3, 32'd7, 32'd5);
      wait_done(lat);
      checks++;
      if (p_out !== (REM_EN ? 48'h0000_0000_001A : 48'h0000_0000_0015)) begin
         errors++;
         $display("FAIL after_abort: p_out=%h expected %h", p_out,
                  REM_EN ? 48'h1A : 48'h15);
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      logic [PW-1:0] exp_q[$];
      logic [QW-1:0] q;
      logic [YW-1:0] y;
      logic [YW-1:0] r;
      logic [PW-1:0] exp;
      int lat;
      int stall;
      for (int n = 0; n < 1000; n++) begin
         q = rand_q();
         y = rand_y();
         r = rand_y();
         issue(q, y, r);
         exp_q.push_back(model(q, y, r));
         wait_done(lat);
         stall = $urandom_range(0, 3);
         exp = exp_q.pop_front();
         for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || p_out !== exp) begin
            errors++;
            $display("FAIL b2b[%0d]: out_valid=%b p_out=%h expected 1/%h (q=%h y=%h r=%h)",
                     n, out_valid, p_out, exp, q, y, r);
         end
         handshake();
      end
   endtask

   initial begin
      test_reset();
      test_zero_operand();
      test_max_operands();
      test_stall();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
